// File: rtl/clint_pkg.sv
// clint_pkg: register offsets, reset values and shared helpers for the CLINT timer.
package clint_pkg;

  typedef logic [63:0] clint_time_t;

  localparam logic [31:0] CLINT_MSIP_OFF        = 32'h0000_0000;
  localparam logic [31:0] CLINT_MTIMECMP_LO_OFF = 32'h0000_4000;
  localparam logic [31:0] CLINT_MTIMECMP_HI_OFF = 32'h0000_4004;
  localparam logic [31:0] CLINT_MTIME_LO_OFF    = 32'h0000_BFF8;
  localparam logic [31:0] CLINT_MTIME_HI_OFF    = 32'h0000_BFFC;

  localparam clint_time_t MTIMECMP_RST = 64'hFFFF_FFFF_FFFF_FFFF;

  typedef enum logic [2:0] {
    REG_NONE,
    REG_MSIP,
    REG_CMP_LO,
    REG_CMP_HI,
    REG_TIME_LO,
    REG_TIME_HI
  } clint_reg_e;

  typedef enum logic {
    BUS_IDLE,
    BUS_ACK
  } bus_state_e;

  // Expects a word-aligned byte address; anything unmapped decodes to REG_NONE.
  function automatic clint_reg_e clint_decode(input logic [31:0] adr);
    clint_reg_e r;
    case (adr)
      CLINT_MSIP_OFF:        r = REG_MSIP;
      CLINT_MTIMECMP_LO_OFF: r = REG_CMP_LO;
      CLINT_MTIMECMP_HI_OFF: r = REG_CMP_HI;
      CLINT_MTIME_LO_OFF:    r = REG_TIME_LO;
      CLINT_MTIME_HI_OFF:    r = REG_TIME_HI;
      default:               r = REG_NONE;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] clint_merge(input logic [31:0] old_val,
                                              input logic [31:0] wdata,
                                              input logic [3:0]  sel);
    logic [31:0] res;
    res = old_val;
    for (int i = 0; i < 4; i++) begin
      if (sel[i]) res[i*8 +: 8] = wdata[i*8 +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/clint_prescaler.sv
// clint_prescaler: free-running 0..PRESCALE-1 counter; tick is high on the last count.
module clint_prescaler
  import clint_pkg::*;
#(
  parameter int PRESCALE = 1
) (
  input  logic clk,
  input  logic reset_n,
  output logic tick
);

  localparam int CNT_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PRESCALE - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    tick  = (cnt_q == CNT_LAST);
    cnt_d = tick ? '0 : cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end

endmodule

// File: rtl/clint_timer.sv
// clint_timer: CLINT mtime/mtimecmp on a Wishbone-classic slave, level timer interrupt.
// Define CLINT_MSIP_EN to implement msip[0] at offset 0x0000 and drive soft_int.
module clint_timer
  import clint_pkg::*;
#(
  parameter int PRESCALE = 1,
  parameter int ADDR_W   = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              wb_cyc_i,
  input  logic              wb_stb_i,
  input  logic              wb_we_i,
  input  logic [ADDR_W-1:0] wb_adr_i,
  input  logic [31:0]       wb_dat_i,
  input  logic [3:0]        wb_sel_i,
  output logic [31:0]       wb_dat_o,
  output logic              wb_ack_o,
  output logic              timer_int,
  output logic              soft_int
);

  bus_state_e  state_q, state_d;
  logic [31:0] dat_q, dat_d;
  clint_time_t mtime_q, mtime_d;
  clint_time_t mtimecmp_q, mtimecmp_d;
  logic        timer_int_q, timer_int_d;

  logic        tick;
  logic        req;
  logic        wr_en;
  logic        msip_bit;
  logic [31:0] adr_word;
  logic [31:0] rdata;
  clint_reg_e  reg_sel;

  clint_prescaler #(.PRESCALE(PRESCALE)) u_prescaler (
    .clk     (clk),
    .reset_n (reset_n),
    .tick    (tick)
  );

  assign adr_word = 32'(wb_adr_i) & 32'hFFFF_FFFC;
  assign reg_sel  = clint_decode(adr_word);
  assign req      = wb_cyc_i & wb_stb_i;

  always_comb begin
    rdata = '0;
    case (reg_sel)
      REG_MSIP:    rdata = {31'b0, msip_bit};
      REG_CMP_LO:  rdata = mtimecmp_q[31:0];
      REG_CMP_HI:  rdata = mtimecmp_q[63:32];
      REG_TIME_LO: rdata = mtime_q[31:0];
      REG_TIME_HI: rdata = mtime_q[63:32];
      default:     rdata = '0;
    endcase
  end

  // The mandatory ACK state is what forces an idle cycle between acks on a held request.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no path infers a latch.
    state_d = state_q;
    dat_d   = '0;
    wr_en   = 1'b0;
    case (state_q)
      BUS_IDLE: begin
        if (req) begin
          state_d = BUS_ACK;
          dat_d   = rdata;
          wr_en   = wb_we_i;
        end
      end
      BUS_ACK: state_d = BUS_IDLE;
      default: state_d = BUS_IDLE;
    endcase
  end

  // A bus write to either mtime half suppresses that cycle's increment entirely.
  always_comb begin
    mtime_d    = mtime_q;
    mtimecmp_d = mtimecmp_q;
    if (wr_en && reg_sel == REG_TIME_LO)
      mtime_d[31:0] = clint_merge(mtime_q[31:0], wb_dat_i, wb_sel_i);
    else if (wr_en && reg_sel == REG_TIME_HI)
      mtime_d[63:32] = clint_merge(mtime_q[63:32], wb_dat_i, wb_sel_i);
    else if (tick)
      mtime_d = mtime_q + 64'd1;

    if (wr_en && reg_sel == REG_CMP_LO)
      mtimecmp_d[31:0] = clint_merge(mtimecmp_q[31:0], wb_dat_i, wb_sel_i);
    if (wr_en && reg_sel == REG_CMP_HI)
      mtimecmp_d[63:32] = clint_merge(mtimecmp_q[63:32], wb_dat_i, wb_sel_i);

    timer_int_d = (mtime_q >= mtimecmp_q);
  end

  always_ff @(posedge clk) begin
    // NOTE: state flops use non-blocking assignment so every flop samples pre-edge values.
    if (!reset_n) begin
      state_q     <= BUS_IDLE;
      dat_q       <= '0;
      mtime_q     <= '0;
      mtimecmp_q  <= MTIMECMP_RST;
      timer_int_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      dat_q       <= dat_d;
      mtime_q     <= mtime_d;
      mtimecmp_q  <= mtimecmp_d;
      timer_int_q <= timer_int_d;
    end
  end

`ifdef CLINT_MSIP_EN
  logic msip_q, msip_d;

  always_comb begin
    msip_d = msip_q;
    if (wr_en && reg_sel == REG_MSIP && wb_sel_i[0]) msip_d = wb_dat_i[0];
  end

  always_ff @(posedge clk) begin
    if (!reset_n) msip_q <= 1'b0;
    else          msip_q <= msip_d;
  end

  assign msip_bit = msip_q;
`else
  assign msip_bit = 1'b0;
`endif

  assign wb_ack_o  = (state_q == BUS_ACK);
  assign wb_dat_o  = dat_q;
  assign timer_int = timer_int_q;
  assign soft_int  = msip_bit;

endmodule
